timer_report_tx: RTL and testbench
==================================

Name: timer_report_tx

Overview:
- Transmit-side companion to the timer command FSM. The FSM consumes UART commands from the RX FIFO; this block answers by writing ASCII status lines into the UART TX FIFO.
- On each timer event (run/stop change, clear, inc, dec) or on an explicit report request, it snapshots the current time and state.
- It then pushes a fixed 12-byte line, "S MM:SS.CC\r\n" or "R MM:SS.CC\r\n", one byte per accepted cycle.

Parameters:
- MIN_W, 6, width of min input.
- SEC_W, 6, width of sec input.
- CS_W, 7, width of centisecond input.
- MSG_LEN, 12, bytes per line (fixed; changing it is not supported).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- run_stop  input  1  level from timer FSM; 1 = RUN
- clear  input  1  one-cycle pulse from timer FSM
- inc  input  1  one-cycle pulse from timer FSM
- dec  input  1  one-cycle pulse from timer FSM
- req  input  1  one-cycle report request (e.g. decoded "T" command)
- min  input  MIN_W  current minutes, binary
- sec  input  SEC_W  current seconds, binary
- cs  input  CS_W  current centiseconds, binary
- fifo_full  input  1  TX FIFO full
- push  output  1  write strobe to TX FIFO
- push_data  output  8  byte to write, valid when push=1
- busy  output  1  line in progress

Behaviour:
- Reset (async): state=IDLE, idx=0, pending=0, snapshot regs=0, run_d=0. Outputs: push=0, push_data=8'h00, busy=0. Reset mid-line aborts the line; no partial resume.
- Event detection: event = req | clear | inc | dec | (run_stop ^ run_d). run_d is a registered copy of run_stop.
- States:
  - IDLE: on event, capture min/sec/cs/run_stop into snapshot regs, idx=0, go to SEND. Event cycle = N; first push possible at N+1.
  - SEND: push = !fifo_full (combinational). push_data = byte[idx] from the snapshot, muxed combinationally. On push, idx++.
  - On the push with idx==11: if pending, re-snapshot, clear pending, idx=0, stay in SEND. Otherwise go to IDLE.
- fifo_full=1 in SEND: push=0, idx holds, no byte lost or duplicated.
- Events while busy: set pending (1-deep). Multiple events coalesce into one follow-up line. An event in the same cycle as the last push is captured as pending.
- Byte map:
  - 0: 'R' if snapshot run else 'S'
  - 1: ' '
  - 2-3: min tens, units
  - 4: ':'
  - 5-6: sec tens, units
  - 7: '.'
  - 8-9: cs tens, units
  - 10: 8'h0D
  - 11: 8'h0A
- Digits are '0'+d. Any value >99 saturates to "99".
- busy = (state != IDLE).
- push_data = 8'h00 when push=0.

Optional Feature:
- PERIODIC_REPORT_EN
- Defined: while run_stop=1, a change of the sec input, detected against a registered copy, is an additional event. This gives one line per second when running.
- Undefined: sec changes are ignored; lines are sent only on the explicit events above.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE, SEND
  - ASCII constants for 'R', 'S', ' ', ':', '.', CR, LF, '0'
  - MSG_LEN
- One sub-module, bin2ascii2: combinational; 7-bit binary in (saturated at 99) to two ASCII digits (tens, units), using divide-by-10 via compare/subtract chain. Instantiated three times.

Test Plan:
- Reset, then req with min=1, sec=23, cs=45, run_stop=0, fifo_full=0 -> 12 consecutive pushes "S 01:23.45\r\n", busy 1 for 12 cycles then 0.
- run_stop 0->1 with min=0, sec=5, cs=0 -> line "R 00:05.00\r\n"; run_stop 1->0 -> "S ..." line.
- fifo_full held 1 for cycles 3-7 of a line -> no push during those cycles; full byte sequence intact afterwards, total 12 pushes.
- inc pulse during busy, then clear pulse also during busy -> exactly one follow-up line using values sampled at the end of the first line; no third line.
- rst asserted after byte 5 of a line -> push=0 immediately, busy=0, next req yields a complete fresh line from byte 0.
- PERIODIC_REPORT_EN defined, run_stop=1, sec 9->10 -> line "R 00:10.xx\r\n". Same stimulus with the macro undefined -> no line.

Source files
------------

// File: rtl/timer_report_tx_pkg.sv
// Shared types and constants for timer_report_tx: FSM states, ASCII codes, line length.
package timer_report_tx_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam int unsigned MSG_LEN = 12;

  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;

  // Clamp an arbitrarily wide binary field to the 0..99 range a two-digit field can show.
  function automatic logic [6:0] sat99(input logic [31:0] v);
    return (v > 32'd99) ? 7'd99 : v[6:0];
  endfunction

endpackage

// File: rtl/timer_report_tx_bin2ascii2.sv
// Binary (0..127, saturated at 99) to two ASCII decimal digits.
module bin2ascii2
  import timer_report_tx_pkg::*;
(
  input  logic [6:0] bin_i,
  output logic [7:0] tens_o,
  output logic [7:0] units_o
);

  logic [6:0] rem;
  logic [3:0] tens;

  // Divide by 10 as a chain of nine conditional subtractions.
  always_comb begin
    rem  = (bin_i > 7'd99) ? 7'd99 : bin_i;
    tens = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    tens_o  = ASCII_0 + {4'b0000, tens};
    units_o = ASCII_0 + {1'b0, rem};
  end

endmodule

// File: rtl/timer_report_tx.sv
// Writes "R/S MM:SS.CC\r\n" status lines into the UART TX FIFO on timer events.
// Optional PERIODIC_REPORT_EN: while running, each change of sec also triggers a line.
module timer_report_tx
  import timer_report_tx_pkg::*;
#(
  parameter int unsigned MIN_W = 6,
  parameter int unsigned SEC_W = 6,
  parameter int unsigned CS_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_stop,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  input  logic             req,
  input  logic [MIN_W-1:0] min,
  input  logic [SEC_W-1:0] sec,
  input  logic [CS_W-1:0]  cs,
  input  logic             fifo_full,
  output logic             push,
  output logic [7:0]       push_data,
  output logic             busy
);

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             run_prev_q;
  logic             snap_run_q, snap_run_d;
  logic [MIN_W-1:0] snap_min_q, snap_min_d;
  logic [SEC_W-1:0] snap_sec_q, snap_sec_d;
  logic [CS_W-1:0]  snap_cs_q, snap_cs_d;
  logic             evt;
  logic [7:0]       msg_byte;
  logic [7:0]       min_t, min_u, sec_t, sec_u, cs_t, cs_u;

`ifdef PERIODIC_REPORT_EN
  logic [SEC_W-1:0] sec_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sec_prev_q <= '0;
    else     sec_prev_q <= sec;
  end

  always_comb evt = req | clear | inc | dec | (run_stop ^ run_prev_q)
                    | (run_stop & (sec != sec_prev_q));
`else
  always_comb evt = req | clear | inc | dec | (run_stop ^ run_prev_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      run_prev_q <= 1'b0;
      snap_run_q <= 1'b0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      snap_cs_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      run_prev_q <= run_stop;
      snap_run_q <= snap_run_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      snap_cs_q  <= snap_cs_d;
    end
  end

  bin2ascii2 u_min (.bin_i(sat99(32'(snap_min_q))), .tens_o(min_t), .units_o(min_u));
  bin2ascii2 u_sec (.bin_i(sat99(32'(snap_sec_q))), .tens_o(sec_t), .units_o(sec_u));
  bin2ascii2 u_cs  (.bin_i(sat99(32'(snap_cs_q))),  .tens_o(cs_t),  .units_o(cs_u));

  always_comb begin
    case (idx_q)
      4'd0:    msg_byte = snap_run_q ? ASCII_R : ASCII_S;
      4'd1:    msg_byte = ASCII_SP;
      4'd2:    msg_byte = min_t;
      4'd3:    msg_byte = min_u;
      4'd4:    msg_byte = ASCII_COLON;
      4'd5:    msg_byte = sec_t;
      4'd6:    msg_byte = sec_u;
      4'd7:    msg_byte = ASCII_DOT;
      4'd8:    msg_byte = cs_t;
      4'd9:    msg_byte = cs_u;
      4'd10:   msg_byte = ASCII_CR;
      4'd11:   msg_byte = ASCII_LF;
      default: msg_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    snap_run_d = snap_run_q;
    snap_min_d = snap_min_q;
    snap_sec_d = snap_sec_q;
    snap_cs_d  = snap_cs_q;
    push       = 1'b0;
    push_data  = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (evt) begin
          snap_run_d = run_stop;
          snap_min_d = min;
          snap_sec_d = sec;
          snap_cs_d  = cs;
          idx_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        push      = !fifo_full;
        push_data = fifo_full ? 8'h00 : msg_byte;
        if (evt) pending_d = 1'b1;
        if (push) begin
          if (idx_q == LAST_IDX) begin
            // An event landing on the final push still earns a follow-up line.
            if (pending_q || evt) begin
              snap_run_d = run_stop;
              snap_min_d = min;
              snap_sec_d = sec;
              snap_cs_d  = cs;
              pending_d  = 1'b0;
              idx_d      = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb busy = (state_q != IDLE);

endmodule

// File: tb/tb_timer_report_tx.sv
// Self-checking bench for timer_report_tx: directed steps plus randomized lines vs. a string-level model.
module tb_timer_report_tx;

  logic       clk = 1'b0;
  logic       rst, run_stop, clear, inc, dec, req, fifo_full;
  logic [5:0] min, sec;
  logic [6:0] cs;
  logic       push, busy;
  logic [7:0] push_data;

  int   checks   = 0;
  int   failures = 0;
  byte  got[$];
  byte  exp_q[$];
  logic last_push, last_busy;

  timer_report_tx #(.MIN_W(6), .SEC_W(6), .CS_W(7)) dut (
    .clk(clk), .rst(rst), .run_stop(run_stop), .clear(clear), .inc(inc), .dec(dec),
    .req(req), .min(min), .sec(sec), .cs(cs), .fifo_full(fifo_full),
    .push(push), .push_data(push_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic expect_line(input bit r, input int m, input int s, input int c);
    string str;
    str = $sformatf("%s %02d:%02d.%02d\r\n", r ? "R" : "S", sat(m), sat(s), sat(c));
    for (int i = 0; i < str.len(); i++) exp_q.push_back(str[i]);
  endtask

  task automatic compare_lines(input string tag);
    int n;
    check({tag, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  // One clock cycle: sample mid-low-phase, then advance to the next falling edge.
  task automatic tick();
    #1;
    last_push = push;
    last_busy = busy;
    if (push) got.push_back(push_data);
    else      check("nopush_data_zero", push_data, 8'h00);
    @(negedge clk);
    req = 0; clear = 0; inc = 0; dec = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_busy && n < 300);
    check({tag, "_timeout"}, (n < 300), 1);
  endtask

  initial begin
    int a_m, a_s, a_c, b_m, b_s, b_c, k, pushes, cyc;
    bit injected;

    rst = 1; run_stop = 0; clear = 0; inc = 0; dec = 0; req = 0; fifo_full = 0;
    min = 0; sec = 0; cs = 0;
    #1;
    check("rst_push", push, 0);
    check("rst_data", push_data, 8'h00);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Basic request: event cycle, then 12 back-to-back pushes.
    min = 1; sec = 23; cs = 45; req = 1;
    tick();
    check("evt_cycle_push", last_push, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("basic_busy%0d", i), last_busy, 1);
      check($sformatf("basic_push%0d", i), last_push, 1);
    end
    tick();
    check("basic_busy_end", last_busy, 0);
    expect_line(0, 1, 23, 45);
    compare_lines("basic");

    // Run/stop edges.
    min = 0; sec = 5; cs = 0;
    tick();
    run_stop = 1;
    tick();
    drain("run");
    expect_line(1, 0, 5, 0);
    compare_lines("run");
    run_stop = 0;
    tick();
    drain("stop");
    expect_line(0, 0, 5, 0);
    compare_lines("stop");

    // Back-pressure in cycles 3-7 of a line; cs saturates.
    min = 59; sec = 7; cs = 120; req = 1;
    tick();
    for (int c = 1; c <= 17; c++) begin
      fifo_full = (c >= 3 && c <= 7);
      tick();
      if (c >= 3 && c <= 7) check($sformatf("full_nopush_c%0d", c), last_push, 0);
    end
    fifo_full = 0;
    tick();
    check("full_busy_end", last_busy, 0);
    expect_line(0, 59, 7, 120);
    compare_lines("full");

    // Two events while busy coalesce into one follow-up with end-of-line values.
    min = 12; sec = 34; cs = 56; req = 1;
    tick();
    min = 40; sec = 41; cs = 99;
    tick(); tick();
    inc = 1;
    tick(); tick(); tick();
    clear = 1;
    tick();
    drain("pend");
    repeat (15) tick();
    expect_line(0, 12, 34, 56);
    expect_line(0, 40, 41, 99);
    compare_lines("pend");

    // Reset mid-line aborts; next request gives a fresh complete line.
    min = 3; sec = 3; cs = 3; req = 1;
    tick();
    repeat (5) tick();
    check("abort_partial", got.size(), 5);
    rst = 1;
    #1;
    check("abort_push", push, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    got.delete();
    min = 9; sec = 8; cs = 7; req = 1;
    tick();
    drain("fresh");
    expect_line(0, 9, 8, 7);
    compare_lines("fresh");

    // Seconds rollover while running.
    min = 0; sec = 9; cs = 33; run_stop = 1;
    tick();
    drain("per_a");
    expect_line(1, 0, 9, 33);
    compare_lines("per_a");
    sec = 10;
`ifdef PERIODIC_REPORT_EN
    tick();
    drain("per_b");
    expect_line(1, 0, 10, 33);
`else
    repeat (20) tick();
`endif
    compare_lines("per_b");
    run_stop = 0;
    tick();
    drain("per_c");
    expect_line(0, 0, 10, 33);
    compare_lines("per_c");

    // Randomized lines with random back-pressure and an optional mid-line event.
    for (int it = 0; it < 10; it++) begin
      a_m = $urandom_range(0, 63); a_s = $urandom_range(0, 63); a_c = $urandom_range(0, 127);
      b_m = $urandom_range(0, 63); b_s = $urandom_range(0, 63); b_c = $urandom_range(0, 127);
      min = 6'(a_m); sec = 6'(a_s); cs = 7'(a_c);
      case ($urandom_range(0, 3))
        0: req = 1;
        1: clear = 1;
        2: inc = 1;
        default: dec = 1;
      endcase
      tick();
      min = 6'(b_m); sec = 6'(b_s); cs = 7'(b_c);
      k = $urandom_range(0, 12);
      pushes = 0; cyc = 0; injected = 0;
      while (cyc < 400) begin
        fifo_full = ($urandom_range(0, 3) == 0);
        if (k < 12 && pushes == k && !injected) begin
          fifo_full = 0;
          if ($urandom_range(0, 1) == 1) inc = 1; else req = 1;
          injected = 1;
        end
        tick();
        cyc++;
        if (last_push) pushes++;
        if (!last_busy) break;
      end
      fifo_full = 0;
      check($sformatf("rnd%0d_timeout", it), (cyc < 400), 1);
      expect_line(0, a_m, a_s, a_c);
      if (injected) expect_line(0, b_m, b_s, b_c);
      compare_lines($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
